// File: rtl/sa_ram_fifo_ctrl_4x128_pkg.sv
// Shared sizing for the 4x128 two-port RAM FIFO controller and its output skid queue.
// The RAM presents read data two cycles after the read address is issued.
package sa_ram_fifo_ctrl_4x128_pkg;

  localparam int SA_RAM_DW     = 128;
  localparam int SA_RAM_AW     = 2;
  localparam int SA_RAM_DEPTH  = 4;
  localparam int SA_RAM_SKID   = 3;
  localparam int SA_RAM_RD_LAT = 2;

  // Read-issue tracking: s1 = RAM output register loading, s2 = RAM data valid.
  typedef struct packed {
    logic s1;
    logic s2;
  } rd_pipe_t;

endpackage

// File: rtl/sa_ram_fifo_ctrl_4x128_skid.sv
// Flop-based FIFO that absorbs RAM read data so downstream stalls never lose in-flight reads.
module sa_ram_skid_fifo
  import sa_ram_fifo_ctrl_4x128_pkg::*;
#(
  parameter int DW   = SA_RAM_DW,
  parameter int SKID = SA_RAM_SKID
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DW-1:0]              din,
  input  logic                       pop,
  output logic [DW-1:0]              head,
  output logic [$clog2(SKID+1)-1:0]  cnt
);

  localparam int PW = (SKID > 1) ? $clog2(SKID) : 1;
  localparam int CW = $clog2(SKID + 1);

  logic [DW-1:0] mem_q [SKID];
  logic [DW-1:0] mem_d [SKID];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) begin
      mem_d[wptr_q] = din;
      wptr_d = (wptr_q == PW'(SKID - 1)) ? {PW{1'b0}} : wptr_q + PW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop) begin
      rptr_d = (rptr_q == PW'(SKID - 1)) ? {PW{1'b0}} : rptr_q + PW'(1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; stored words are not cleared on reset, only the pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wptr_q <= {PW{1'b0}};
      rptr_q <= {PW{1'b0}};
      cnt_q  <= {CW{1'b0}};
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head = mem_q[rptr_q];
  assign cnt  = cnt_q;

endmodule

// File: rtl/sa_ram_fifo_ctrl_4x128.sv
// Valid/ready FIFO controller around a 4x128 two-port RAM with a 2-cycle registered read.
// Reads are issued only when the skid queue has a guaranteed slot, giving 1 word/cycle each way.
module sa_ram_fifo_ctrl_4x128
  import sa_ram_fifo_ctrl_4x128_pkg::*;
#(
  parameter int DW    = SA_RAM_DW,
  parameter int AW    = SA_RAM_AW,
  parameter int DEPTH = SA_RAM_DEPTH,
  parameter int SKID  = SA_RAM_SKID
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_pvld,
  output logic          wr_prdy,
  input  logic [DW-1:0] wr_pd,
  output logic          rd_pvld,
  input  logic          rd_prdy,
  output logic [DW-1:0] rd_pd,
  output logic [AW-1:0] ram_wa,
  output logic          ram_we,
  output logic [DW-1:0] ram_di,
  output logic [AW-1:0] ram_ra,
  output logic          ram_re,
  output logic          ram_ore,
  input  logic [DW-1:0] ram_dout,
  output logic          idle
);

  localparam int CW  = $clog2(DEPTH + 1);
  localparam int SCW = $clog2(SKID + 1);
  localparam int KW  = $clog2(SKID + 3);

  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  ram_cnt_q, ram_cnt_d;
  rd_pipe_t       pipe_q, pipe_d;
  logic [SCW-1:0] skid_cnt;
  logic [KW-1:0]  credit_use;
  logic           push, pop_ram, rd_take;

  // Handshakes and read-credit check; a word leaving the skid this cycle frees its slot.
  always_comb begin
    wr_prdy    = (ram_cnt_q != CW'(DEPTH));
    rd_pvld    = (skid_cnt != {SCW{1'b0}});
    push       = wr_pvld & wr_prdy & ~rst;
    rd_take    = rd_pvld & rd_prdy;
    credit_use = KW'(skid_cnt) + KW'(pipe_q.s1) + KW'(pipe_q.s2) - KW'(rd_take);
    if (rst) begin
      pop_ram = 1'b0;
    end else begin
      pop_ram = (ram_cnt_q != {CW{1'b0}}) & (credit_use <= KW'(SKID - 1));
    end
  end

  // Pointer, occupancy and read-pipeline next state.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ram_cnt_d = ram_cnt_q;
    pipe_d.s1 = pop_ram;
    pipe_d.s2 = pipe_q.s1;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? {AW{1'b0}} : wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ram) begin
      rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? {AW{1'b0}} : rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop_ram})
      2'b10:   ram_cnt_d = ram_cnt_q + CW'(1);
      2'b01:   ram_cnt_d = ram_cnt_q - CW'(1);
      default: ram_cnt_d = ram_cnt_q;
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= {AW{1'b0}};
      rd_ptr_q  <= {AW{1'b0}};
      ram_cnt_q <= {CW{1'b0}};
      pipe_q    <= '{s1: 1'b0, s2: 1'b0};
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      pipe_q    <= pipe_d;
    end
  end

  assign ram_we  = push;
  assign ram_wa  = wr_ptr_q;
  assign ram_di  = wr_pd;
  assign ram_re  = pop_ram;
  assign ram_ra  = rd_ptr_q;
  assign ram_ore = pipe_q.s1;
  assign idle    = (ram_cnt_q == {CW{1'b0}}) & ~pipe_q.s1 & ~pipe_q.s2
                 & (skid_cnt == {SCW{1'b0}});

  // RAM output is valid while s2 is set, so it is captured at the end of that cycle.
  sa_ram_skid_fifo #(
    .DW   (DW),
    .SKID (SKID)
  ) u_skid (
    .clk  (clk),
    .rst  (rst),
    .push (pipe_q.s2),
    .din  (ram_dout),
    .pop  (rd_take),
    .head (rd_pd),
    .cnt  (skid_cnt)
  );

endmodule
